// File: rtl/motion_pkg.sv
// Shared constants for the motion search controller: widths, state encoding, default centre.
package motion_pkg;

    localparam int unsigned OFS_W = 6;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned TMO_W = 16;

    localparam logic [OFS_W-1:0] DEF_CENTER = 6'd32;
    localparam logic [SUM_W-1:0] SUM_MAX    = 16'hFFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/motion_search_ctrl_scanner.sv
// Raster x/y offset counter (x inner, y outer) with a last-point flag.
module offset_scanner
    import motion_pkg::*;
#(
    parameter int unsigned      X_MIN   = 16,
    parameter int unsigned      X_MAX   = 48,
    parameter int unsigned      Y_MIN   = 16,
    parameter int unsigned      Y_MAX   = 48,
    parameter logic [OFS_W-1:0] RST_VAL = DEF_CENTER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             advance,
    output logic [OFS_W-1:0] x,
    output logic [OFS_W-1:0] y,
    output logic             last_c
);

    // Offset registers: load window origin on init, step in raster order on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= RST_VAL;
            y <= RST_VAL;
        end else if (init) begin
            x <= OFS_W'(X_MIN);
            y <= OFS_W'(Y_MIN);
        end else if (advance) begin
            if (x == OFS_W'(X_MAX)) begin
                x <= OFS_W'(X_MIN);
                y <= y + OFS_W'(1);
            end else begin
                x <= x + OFS_W'(1);
            end
        end
    end

    assign last_c = (x == OFS_W'(X_MAX)) && (y == OFS_W'(Y_MAX));

endmodule

// File: rtl/motion_search_ctrl.sv
// Sweeps an offset window through the correlator and keeps the minimum-sum offset.
module motion_search_ctrl
    import motion_pkg::*;
#(
    parameter int unsigned      X_MIN   = 16,
    parameter int unsigned      X_MAX   = 48,
    parameter int unsigned      Y_MIN   = 16,
    parameter int unsigned      Y_MAX   = 48,
    parameter logic [OFS_W-1:0] CENTER  = DEF_CENTER,
    parameter logic [TMO_W-1:0] TIMEOUT = 16'd4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             frame_sel_in,
    output logic             core_go,
    output logic [OFS_W-1:0] core_x_offset,
    output logic [OFS_W-1:0] core_y_offset,
    output logic             core_frame_sel,
    input  logic [SUM_W-1:0] core_corr_sum,
    input  logic             core_done,
    output logic             busy,
    output logic             search_done,
    output logic             result_valid,
    output logic [OFS_W-1:0] best_x_offset,
    output logic [OFS_W-1:0] best_y_offset,
    output logic [OFS_W-1:0] best_dx,
    output logic [OFS_W-1:0] best_dy,
    output logic [SUM_W-1:0] best_sum,
    output logic             timeout_err
);

    logic [1:0]       state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             go_nxt, frame_sel_nxt, busy_nxt, done_nxt, valid_nxt, tmo_err_nxt;
    logic [OFS_W-1:0] best_x_nxt, best_y_nxt, best_dx_nxt, best_dy_nxt;
    logic [SUM_W-1:0] best_sum_nxt;
    logic             scan_init, scan_adv, scan_last;

    offset_scanner #(
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX),
        .RST_VAL (CENTER)
    ) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .init    (scan_init),
        .advance (scan_adv),
        .x       (core_x_offset),
        .y       (core_y_offset),
        .last_c  (scan_last)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            tmo_cnt        <= '0;
            core_go        <= 1'b0;
            core_frame_sel <= 1'b0;
            busy           <= 1'b0;
            search_done    <= 1'b0;
            result_valid   <= 1'b0;
            timeout_err    <= 1'b0;
            best_x_offset  <= '0;
            best_y_offset  <= '0;
            best_dx        <= '0;
            best_dy        <= '0;
            best_sum       <= '0;
        end else begin
            state          <= state_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            core_go        <= go_nxt;
            core_frame_sel <= frame_sel_nxt;
            busy           <= busy_nxt;
            search_done    <= done_nxt;
            result_valid   <= valid_nxt;
            timeout_err    <= tmo_err_nxt;
            best_x_offset  <= best_x_nxt;
            best_y_offset  <= best_y_nxt;
            best_dx        <= best_dx_nxt;
            best_dy        <= best_dy_nxt;
            best_sum       <= best_sum_nxt;
        end
    end

    // Next-state and next-output logic; abort has priority over core_done.
    always_comb begin
        state_nxt     = state;
        tmo_cnt_nxt   = tmo_cnt;
        go_nxt        = core_go;
        frame_sel_nxt = core_frame_sel;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        valid_nxt     = result_valid;
        tmo_err_nxt   = timeout_err;
        best_x_nxt    = best_x_offset;
        best_y_nxt    = best_y_offset;
        best_dx_nxt   = best_dx;
        best_dy_nxt   = best_dy;
        best_sum_nxt  = best_sum;
        scan_init     = 1'b0;
        scan_adv      = 1'b0;

        case (state)
            ST_IDLE: begin
                go_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (start) begin
                    frame_sel_nxt = frame_sel_in;
                    scan_init     = 1'b1;
                    best_sum_nxt  = SUM_MAX;
                    best_x_nxt    = OFS_W'(X_MIN);
                    best_y_nxt    = OFS_W'(Y_MIN);
                    best_dx_nxt   = OFS_W'(X_MIN) - CENTER;
                    best_dy_nxt   = OFS_W'(Y_MIN) - CENTER;
                    valid_nxt     = 1'b0;
                    tmo_err_nxt   = 1'b0;
                    tmo_cnt_nxt   = '0;
                    go_nxt        = 1'b1;
                    busy_nxt      = 1'b1;
                    state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    go_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (core_done) begin
                    if (core_corr_sum < best_sum) begin
                        best_sum_nxt = core_corr_sum;
                        best_x_nxt   = core_x_offset;
                        best_y_nxt   = core_y_offset;
                        best_dx_nxt  = core_x_offset - CENTER;
                        best_dy_nxt  = core_y_offset - CENTER;
                    end
                    go_nxt    = 1'b0;
                    state_nxt = ST_GAP;
                end else if (tmo_cnt + TMO_W'(1) == TIMEOUT) begin
                    go_nxt      = 1'b0;
                    busy_nxt    = 1'b0;
                    tmo_err_nxt = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    go_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (scan_last) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    scan_adv    = 1'b1;
                    tmo_cnt_nxt = '0;
                    go_nxt      = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
            default: begin
                go_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_motion_search_ctrl.sv
// Directed bench: 5x5 window search, tie handling, single point, timeout, abort, reset.
module tb_motion_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks = 0;
    int   errors = 0;

    // DUT 0: window 30..34 x 30..34, short timeout
    logic        start, abort, frame_sel_in;
    logic        core_go, core_frame_sel, core_done;
    logic [5:0]  core_x_offset, core_y_offset;
    logic [15:0] core_corr_sum;
    logic        busy, search_done, result_valid, timeout_err;
    logic [5:0]  best_x_offset, best_y_offset, best_dx, best_dy;
    logic [15:0] best_sum;

    // DUT 1: single point at 32,32
    logic        start1, abort1, frame_sel_in1;
    logic        core_go1, core_frame_sel1, core_done1;
    logic [5:0]  core_x_offset1, core_y_offset1;
    logic [15:0] core_corr_sum1;
    logic        busy1, search_done1, result_valid1, timeout_err1;
    logic [5:0]  best_x_offset1, best_y_offset1, best_dx1, best_dy1;
    logic [15:0] best_sum1;

    motion_search_ctrl #(
        .X_MIN(30), .X_MAX(34), .Y_MIN(30), .Y_MAX(34), .CENTER(6'd32), .TIMEOUT(16'd20)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_sel_in(frame_sel_in),
        .core_go(core_go), .core_x_offset(core_x_offset), .core_y_offset(core_y_offset),
        .core_frame_sel(core_frame_sel), .core_corr_sum(core_corr_sum), .core_done(core_done),
        .busy(busy), .search_done(search_done), .result_valid(result_valid),
        .best_x_offset(best_x_offset), .best_y_offset(best_y_offset),
        .best_dx(best_dx), .best_dy(best_dy), .best_sum(best_sum), .timeout_err(timeout_err)
    );

    motion_search_ctrl #(
        .X_MIN(32), .X_MAX(32), .Y_MIN(32), .Y_MAX(32), .CENTER(6'd32), .TIMEOUT(16'd4095)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .frame_sel_in(frame_sel_in1),
        .core_go(core_go1), .core_x_offset(core_x_offset1), .core_y_offset(core_y_offset1),
        .core_frame_sel(core_frame_sel1), .core_corr_sum(core_corr_sum1), .core_done(core_done1),
        .busy(busy1), .search_done(search_done1), .result_valid(result_valid1),
        .best_x_offset(best_x_offset1), .best_y_offset(best_y_offset1),
        .best_dx(best_dx1), .best_dy(best_dy1), .best_sum(best_sum1), .timeout_err(timeout_err1)
    );

    // Correlator model for DUT 0: done on the 8th go cycle, optional withheld run
    int   withhold_run = 0;
    int   sum_mode     = 0;
    int   m0_cnt;
    int   run_num;
    logic go_d;

    function automatic logic [15:0] model_sum(input logic [5:0] x, input logic [5:0] y);
        int dx, dy;
        dx = int'(x) - 32;
        dy = int'(y) - 31;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return 16'(dx + dy + 5);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m0_cnt        <= 0;
            run_num       <= 0;
            go_d          <= 1'b0;
            core_done     <= 1'b0;
            core_corr_sum <= '0;
        end else begin
            go_d <= core_go;
            if (!busy) run_num <= 0;
            else if (core_go && !go_d) run_num <= run_num + 1;
            if (!core_go) begin
                m0_cnt    <= 0;
                core_done <= 1'b0;
            end else begin
                m0_cnt        <= m0_cnt + 1;
                core_done     <= (m0_cnt == 6) && (run_num != withhold_run);
                core_corr_sum <= (sum_mode == 1) ? 16'd100 : model_sum(core_x_offset, core_y_offset);
            end
        end
    end

    // Correlator model for DUT 1: done on the 10th go cycle, sum 7
    int m1_cnt;
    always @(posedge clk) begin
        if (reset || !core_go1) begin
            m1_cnt         <= 0;
            core_done1     <= 1'b0;
            core_corr_sum1 <= 16'd7;
        end else begin
            m1_cnt     <= m1_cnt + 1;
            core_done1 <= (m1_cnt == 8);
        end
    end

    // Drive start for one sampled cycle; returns in cycle 1 after acceptance.
    task automatic pulse_start(input logic fs);
        @(negedge clk);
        start        = 1'b1;
        frame_sel_in = fs;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Run a full search on DUT 0 and count search_done pulses and runs.
    task automatic run_search(input logic fs, output int n_done, output int n_runs);
        logic prev_go;
        n_done  = 0;
        n_runs  = 0;
        prev_go = 1'b0;
        pulse_start(fs);
        for (int i = 0; i < 1000; i++) begin
            if (search_done) n_done++;
            if (core_go && !prev_go) n_runs++;
            prev_go = core_go;
            if (n_done > 0 && !busy) break;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (search_done) n_done++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 0; abort = 0; frame_sel_in = 0;
        start1 = 0; abort1 = 0; frame_sel_in1 = 0;
        repeat (3) @(negedge clk);
        checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %0h expected 0", core_go); end
        checks++; if (core_x_offset !== 6'd32) begin errors++; $display("FAIL reset_x: got %0d expected 32", core_x_offset); end
        checks++; if (core_y_offset !== 6'd32) begin errors++; $display("FAIL reset_y: got %0d expected 32", core_y_offset); end
        checks++; if ({busy, search_done, result_valid, timeout_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, search_done, result_valid, timeout_err}); end
        checks++; if ({best_x_offset, best_y_offset, best_sum} !== 28'd0) begin errors++; $display("FAIL reset_best: got %0h expected 0", {best_x_offset, best_y_offset, best_sum}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_min_search();
        int nd, nr;
        sum_mode = 0; withhold_run = 0;
        run_search(1'b1, nd, nr);
        checks++; if (nd !== 1) begin errors++; $display("FAIL min_done_count: got %0d expected 1", nd); end
        checks++; if (nr !== 25) begin errors++; $display("FAIL min_runs: got %0d expected 25", nr); end
        checks++; if (best_x_offset !== 6'd32) begin errors++; $display("FAIL min_best_x: got %0d expected 32", best_x_offset); end
        checks++; if (best_y_offset !== 6'd31) begin errors++; $display("FAIL min_best_y: got %0d expected 31", best_y_offset); end
        checks++; if (best_dx !== 6'h00) begin errors++; $display("FAIL min_dx: got %0h expected 0", best_dx); end
        checks++; if (best_dy !== 6'h3F) begin errors++; $display("FAIL min_dy: got %0h expected 3f", best_dy); end
        checks++; if (best_sum !== 16'd5) begin errors++; $display("FAIL min_sum: got %0d expected 5", best_sum); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL min_valid: got %0h expected 1", result_valid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL min_tmo: got %0h expected 0", timeout_err); end
        checks++; if (core_frame_sel !== 1'b1) begin errors++; $display("FAIL min_frame_sel: got %0h expected 1", core_frame_sel); end
    endtask

    task automatic test_tie_search();
        int nd, nr;
        sum_mode = 1; withhold_run = 0;
        run_search(1'b0, nd, nr);
        checks++; if (nd !== 1) begin errors++; $display("FAIL tie_done_count: got %0d expected 1", nd); end
        checks++; if (nr !== 25) begin errors++; $display("FAIL tie_runs: got %0d expected 25", nr); end
        checks++; if ({best_x_offset, best_y_offset} !== {6'd30, 6'd30}) begin errors++; $display("FAIL tie_best_xy: got %0d,%0d expected 30,30", best_x_offset, best_y_offset); end
        checks++; if ({best_dx, best_dy} !== {6'h3E, 6'h3E}) begin errors++; $display("FAIL tie_dxdy: got %0h,%0h expected 3e,3e", best_dx, best_dy); end
        checks++; if (best_sum !== 16'd100) begin errors++; $display("FAIL tie_sum: got %0d expected 100", best_sum); end
        checks++; if (core_frame_sel !== 1'b0) begin errors++; $display("FAIL tie_frame_sel: got %0h expected 0", core_frame_sel); end
    endtask

    task automatic test_single_point();
        int   cyc, sd_cyc;
        logic go_c1, go_c11;
        sd_cyc = -1;
        go_c11 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc    = 1;
        go_c1  = core_go1;
        while (cyc <= 30) begin
            if (search_done1 && sd_cyc < 0) sd_cyc = cyc;
            if (cyc == 11) go_c11 = core_go1;
            @(negedge clk);
            cyc++;
        end
        checks++; if (go_c1 !== 1'b1) begin errors++; $display("FAIL single_go_c1: got %0h expected 1", go_c1); end
        checks++; if (go_c11 !== 1'b0) begin errors++; $display("FAIL single_go_c11: got %0h expected 0", go_c11); end
        checks++; if (sd_cyc !== 12) begin errors++; $display("FAIL single_done_cycle: got %0d expected 12", sd_cyc); end
        checks++; if (result_valid1 !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h expected 1", result_valid1); end
        checks++; if ({best_dx1, best_dy1} !== 12'd0) begin errors++; $display("FAIL single_dxdy: got %0h,%0h expected 0,0", best_dx1, best_dy1); end
        checks++; if ({best_x_offset1, best_sum1} !== {6'd32, 16'd7}) begin errors++; $display("FAIL single_best: got %0d/%0d expected 32/7", best_x_offset1, best_sum1); end
    endtask

    task automatic test_timeout();
        int   runs, go3, nd;
        logic prev_go, go_at_done;
        runs = 0; go3 = 0; nd = 0; prev_go = 1'b0; go_at_done = 1'b1;
        sum_mode = 0; withhold_run = 3;
        pulse_start(1'b0);
        for (int i = 0; i < 500; i++) begin
            if (core_go && !prev_go) runs++;
            if (core_go && runs == 3) go3++;
            prev_go = core_go;
            if (search_done) begin
                nd++;
                go_at_done = core_go;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (search_done) nd++;
        end
        withhold_run = 0;
        checks++; if (nd !== 1) begin errors++; $display("FAIL tmo_done_count: got %0d expected 1", nd); end
        checks++; if (go3 !== 20) begin errors++; $display("FAIL tmo_run_cycles: got %0d expected 20", go3); end
        checks++; if (go_at_done !== 1'b0) begin errors++; $display("FAIL tmo_go_at_done: got %0h expected 0", go_at_done); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0h expected 1", timeout_err); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL tmo_valid: got %0h expected 0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_abort();
        int   runs, nd;
        logic prev_go, go_seen;
        runs = 0; nd = 0; prev_go = 1'b0; go_seen = 1'b0;
        pulse_start(1'b1);
        for (int i = 0; i < 200 && runs < 5; i++) begin
            if (core_go && !prev_go) runs++;
            prev_go = core_go;
            if (runs < 5) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (runs !== 5) begin errors++; $display("FAIL abort_reached_run5: got %0d expected 5", runs); end
        checks++; if ({core_go, busy} !== 2'b00) begin errors++; $display("FAIL abort_go_busy: got %b expected 00", {core_go, busy}); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0h expected 0", result_valid); end
        for (int i = 0; i < 30; i++) begin
            if (search_done) nd++;
            if (core_go) go_seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
        checks++; if (go_seen !== 1'b0) begin errors++; $display("FAIL abort_go_idle: got %0h expected 0", go_seen); end
        pulse_start(1'b0);
        checks++; if ({core_go, core_x_offset, core_y_offset} !== {1'b1, 6'd30, 6'd30}) begin errors++; $display("FAIL abort_restart: got go=%0h x=%0d y=%0d expected go=1 x=30 y=30", core_go, core_x_offset, core_y_offset); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pulse_start(1'b1);
        // run 1 lasts 8 go cycles plus one gap; land inside run 2
        repeat (11) @(negedge clk);
        start        = 1'b1;
        frame_sel_in = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        checks++; if (core_frame_sel !== 1'b1) begin errors++; $display("FAIL b2b_frame_sel: got %0h expected 1", core_frame_sel); end
        checks++; if ({core_go, busy, core_x_offset, core_y_offset} !== {1'b1, 1'b1, 6'd31, 6'd30}) begin errors++; $display("FAIL b2b_no_restart: got go=%0h busy=%0h x=%0d y=%0d expected 1 1 31 30", core_go, busy, core_x_offset, core_y_offset); end
    endtask

    task automatic test_reset_mid_run();
        // still mid-search from the previous task, frame_sel latched as 1
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({core_go, busy, core_frame_sel, result_valid, search_done} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {core_go, busy, core_frame_sel, result_valid, search_done}); end
        checks++; if ({core_x_offset, core_y_offset} !== {6'd32, 6'd32}) begin errors++; $display("FAIL rst_mid_offsets: got %0d,%0d expected 32,32", core_x_offset, core_y_offset); end
        checks++; if ({best_x_offset, best_sum} !== 22'd0) begin errors++; $display("FAIL rst_mid_best: got %0d/%0d expected 0/0", best_x_offset, best_sum); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_min_search();
        test_tie_search();
        test_single_point();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
